// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encodings, default
// master count and the grant index width derived from it.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS_DEF = 3;
    localparam int GRANT_ID_W      = $clog2(NUM_MASTERS_DEF);
    localparam int HOLD_CNT_W      = 16;
    localparam int GAP_CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARBITRATE = 3'd1,
        ST_GRANTED   = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: lowest-indexed requester at or after last_id+1, wrapping.
// Purely combinational; o_vld low when no request is present.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int ID_W        = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [ID_W-1:0]        i_last_id,
    output logic                   o_vld,
    output logic [ID_W-1:0]        o_idx
);

    logic [ID_W-1:0] w_cand;

    // Scan farthest offset first so the nearest requester is the last to win.
    always_comb begin
        o_vld  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_cand = ID_W'((int'(i_last_id) + k) % NUM_MASTERS);
            if (i_req[w_cand]) begin
                o_vld = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold-limit revocation and forced inter-grant gap; grant 2 cycles after req from IDLE.
// No backpressure: slave_busy only stretches a released grant; timeout_err is high in the cycle after the last held cycle.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int HOLD_LIMIT  = 255,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           slave_busy,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic                           bus_util,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           timeout_err
);

    localparam int ID_W = $clog2(NUM_MASTERS);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_LIMIT);
    localparam logic [GAP_CNT_W-1:0]  GAP_LIM  = GAP_CNT_W'(GAP_CYCLES);

    arb_state_t               r_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic                     r_bus_util;
    logic [ID_W-1:0]          r_grant_id;
    logic [ID_W-1:0]          r_last_id;
    logic                     r_timeout;
    logic [HOLD_CNT_W-1:0]    r_hold;
    logic [GAP_CNT_W-1:0]     r_gap;

    arb_state_t               w_state_nxt;
    logic [NUM_MASTERS-1:0]   w_grant_nxt;
    logic [ID_W-1:0]          w_grant_id_nxt;
    logic [ID_W-1:0]          w_last_id_nxt;
    logic                     w_timeout_nxt;
    logic [HOLD_CNT_W-1:0]    w_hold_nxt;
    logic [GAP_CNT_W-1:0]     w_gap_nxt;
    logic [HOLD_CNT_W-1:0]    w_hold_inc;
    logic [GAP_CNT_W-1:0]     w_gap_inc;
    logic                     w_pick_vld;
    logic [ID_W-1:0]          w_pick_idx;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_last_id (r_last_id),
        .o_vld     (w_pick_vld),
        .o_idx     (w_pick_idx)
    );

    assign w_hold_inc = r_hold + HOLD_CNT_W'(1);
    assign w_gap_inc  = r_gap + GAP_CNT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_last_id_nxt  = r_last_id;
        w_timeout_nxt  = 1'b0;
        w_hold_nxt     = r_hold;
        w_gap_nxt      = r_gap;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (|req) w_state_nxt = ST_ARBITRATE;
            end
            ST_ARBITRATE: begin
                if (w_pick_vld) begin
                    w_state_nxt    = ST_GRANTED;
                    w_grant_nxt    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;
                    w_grant_id_nxt = w_pick_idx;
                    w_last_id_nxt  = w_pick_idx;
                    w_hold_nxt     = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                w_hold_nxt = w_hold_inc;
                // The hold limit overrides both req and slave_busy.
                if (w_hold_inc == HOLD_LIM) begin
                    w_state_nxt   = ST_RELEASE;
                    w_grant_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                end else if (!req[r_grant_id] && !slave_busy) begin
                    w_state_nxt = ST_RELEASE;
                    w_grant_nxt = '0;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_GAP;
                w_grant_nxt = '0;
                w_gap_nxt   = '0;
            end
            ST_GAP: begin
                w_grant_nxt = '0;
                w_gap_nxt   = w_gap_inc;
                if (w_gap_inc == GAP_LIM) begin
                    w_state_nxt = (|req) ? ST_ARBITRATE : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_bus_util <= 1'b0;
            r_grant_id <= '0;
            r_last_id  <= ID_W'(NUM_MASTERS - 1);
            r_timeout  <= 1'b0;
            r_hold     <= '0;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_bus_util <= |w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_last_id  <= w_last_id_nxt;
            r_timeout  <= w_timeout_nxt;
            r_hold     <= w_hold_nxt;
            r_gap      <= w_gap_nxt;
        end
    end

    assign grant       = r_grant;
    assign bus_util    = r_bus_util;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (hold limit 255 and 8) share stimulus and
// are compared every cycle against a timer-based model, plus directed literal checks.
module tb_bus_arbiter;

    localparam int N   = 3;
    localparam int GAP = 2;

    logic         clk        = 1'b0;
    logic         rstn       = 1'b0;
    logic [N-1:0] req        = '0;
    logic         slave_busy = 1'b0;

    logic [N-1:0] dut_grant [2];
    logic         dut_util  [2];
    logic [1:0]   dut_id    [2];
    logic         dut_to    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_MASTERS(N), .HOLD_LIMIT(255), .GAP_CYCLES(GAP)) u_dut_long (
        .clk(clk), .rstn(rstn), .req(req), .slave_busy(slave_busy),
        .grant(dut_grant[0]), .bus_util(dut_util[0]), .grant_id(dut_id[0]), .timeout_err(dut_to[0])
    );

    bus_arbiter #(.NUM_MASTERS(N), .HOLD_LIMIT(8), .GAP_CYCLES(GAP)) u_dut_short (
        .clk(clk), .rstn(rstn), .req(req), .slave_busy(slave_busy),
        .grant(dut_grant[1]), .bus_util(dut_util[1]), .grant_id(dut_id[1]), .timeout_err(dut_to[1])
    );

    // Model: owner of the bus, cycles held, quiet cycles left after a grant ends
    // (release + gap), and whether the next edge is the arbitration decision.
    typedef struct {
        int owner;
        int held;
        int quiet;
        int last;
        int id;
        bit arb;
        bit to;
    } mstate_t;

    mstate_t m [2];

    function automatic int hold_limit(input int i);
        return (i == 0) ? 255 : 8;
    endfunction

    function automatic mstate_t reset_state();
        mstate_t s;
        s.owner = -1; s.held = 0; s.quiet = 0; s.last = N - 1; s.id = 0; s.arb = 1'b0; s.to = 1'b0;
        return s;
    endfunction

    function automatic mstate_t step(input mstate_t s, input int hl, input logic [N-1:0] r, input logic busy);
        mstate_t n;
        bit found;
        n = s;
        n.to = 1'b0;
        if (s.owner >= 0) begin
            n.held = s.held + 1;
            if (n.held == hl) begin
                n.to = 1'b1; n.owner = -1; n.quiet = 1 + GAP;
            end else if (!r[s.owner] && !busy) begin
                n.owner = -1; n.quiet = 1 + GAP;
            end
        end else if (s.arb) begin
            n.arb = 1'b0;
            found = 1'b0;
            for (int off = 1; off <= N; off++) begin
                if (!found && r[(s.last + off) % N]) begin
                    found = 1'b1;
                    n.owner = (s.last + off) % N;
                end
            end
            if (found) begin
                n.id = n.owner; n.last = n.owner; n.held = 0;
            end
        end else if (s.quiet > 0) begin
            n.quiet = s.quiet - 1;
            if (n.quiet == 0 && r != 0) n.arb = 1'b1;
        end else if (r != 0) begin
            n.arb = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [N-1:0] exp_grant(input mstate_t s);
        logic [N-1:0] v;
        v = '0;
        if (s.owner >= 0) v[s.owner] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) m[i] <= reset_state();
            else       m[i] <= step(m[i], hold_limit(i), req, slave_busy);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_grant[%0d]", i), int'(dut_grant[i]), int'(exp_grant(m[i])));
            check($sformatf("model_util[%0d]", i), int'(dut_util[i]), int'(m[i].owner >= 0));
            check($sformatf("model_id[%0d]", i), int'(dut_id[i]), m[i].id);
            check($sformatf("model_timeout[%0d]", i), int'(dut_to[i]), int'(m[i].to));
            check($sformatf("onehot[%0d]", i), int'($countones(dut_grant[i]) <= 1), 1);
            check($sformatf("util_is_or_grant[%0d]", i), int'(dut_util[i]), int'(|dut_grant[i]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check outputs cleared at once, release with req=r.
    task automatic do_reset(input logic [N-1:0] r);
        @(posedge clk);
        #3;
        rstn = 1'b0; req = '0; slave_busy = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_grant[%0d]", i), int'(dut_grant[i]), 0);
            check($sformatf("rst_util[%0d]", i), int'(dut_util[i]), 0);
            check($sformatf("rst_id[%0d]", i), int'(dut_id[i]), 0);
            check($sformatf("rst_timeout[%0d]", i), int'(dut_to[i]), 0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1; req = r;
    endtask

    task automatic wait_grant(output logic [N-1:0] g, output int idle);
        g = '0;
        idle = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (dut_grant[0] != '0) begin
                g = dut_grant[0];
                break;
            end
            idle++;
        end
        check("grant_wait_bounded", int'(g != '0), 1);
    endtask

    logic [N-1:0] rot [4];
    logic [N-1:0] g;
    int           idle;

    initial begin
        rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;

        // Single request: grant two edges after release of reset.
        do_reset(3'b010);
        tick(1);
        check("single_arb_cycle_grant", int'(dut_grant[0]), 0);
        tick(1);
        check("single_grant", int'(dut_grant[0]), 3'b010);
        check("single_util", int'(dut_util[0]), 1);
        check("single_id", int'(dut_id[0]), 1);
        req = '0;
        tick(1);
        check("single_release", int'(dut_grant[0]), 0);

        // Contention: each grantee holds 5 cycles; bus is down for
        // release + GAP gap cycles + the arbitration cycle between grants.
        do_reset(3'b111);
        for (int n = 0; n < 4; n++) begin
            wait_grant(g, idle);
            check($sformatf("rot_grant%0d", n), int'(g), int'(rot[n]));
            if (n > 0) check($sformatf("rot_idle%0d", n), idle + 1, 1 + GAP + 1);
            tick(4);
            req = req & ~g;
            tick(1);
            check($sformatf("rot_drop%0d", n), int'(dut_grant[0]), 0);
            req = req | g;
        end

        // Slave hold: grant outlives req while slave_busy is high.
        do_reset(3'b001);
        tick(2);
        check("hold_grant", int'(dut_grant[0]), 3'b001);
        req = '0; slave_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check($sformatf("hold_busy%0d", k), int'(dut_grant[0]), 3'b001);
        end
        slave_busy = 1'b0;
        tick(1);
        check("hold_drop_grant", int'(dut_grant[0]), 0);
        check("hold_drop_util", int'(dut_util[0]), 0);

        // Timeout on the HOLD_LIMIT=8 instance; master 1 is served next.
        do_reset(3'b011);
        tick(2);
        check("to_first_grant", int'(dut_grant[1]), 3'b001);
        tick(7);
        check("to_grant_cycle8", int'(dut_grant[1]), 3'b001);
        check("to_not_yet", int'(dut_to[1]), 0);
        tick(1);
        check("to_grant_dropped", int'(dut_grant[1]), 0);
        check("to_pulse", int'(dut_to[1]), 1);
        tick(1);
        check("to_pulse_ends", int'(dut_to[1]), 0);
        tick(3);
        check("to_next_grant", int'(dut_grant[1]), 3'b010);
        check("to_next_id", int'(dut_id[1]), 1);
        check("to_long_still_held", int'(dut_grant[0]), 3'b001);

        // Reset while instance 0 is mid-grant, then req=110 selects master 1.
        do_reset(3'b110);
        tick(2);
        check("rst_after_grant", int'(dut_grant[0]), 3'b010);
        check("rst_after_id", int'(dut_id[0]), 1);
        check("rst_after_util", int'(dut_util[0]), 1);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
